// File: rtl/kanagawa_logic_ram_writer_if.sv
// Request handshake and RAM write-port bundle for kanagawa_logic_ram_writer.
interface kanagawa_logic_ram_writer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_in;
    logic                  req_ready_out;
    logic [ADDR_WIDTH-1:0] req_addr_in;
    logic [DATA_WIDTH-1:0] req_data_in;
    logic                  wren_out;
    logic [ADDR_WIDTH-1:0] wraddr_out;
    logic [DATA_WIDTH-1:0] wrdata_out;

    modport slave (
        input  req_valid_in, req_addr_in, req_data_in,
        output req_ready_out, wren_out, wraddr_out, wrdata_out
    );

    modport master (
        output req_valid_in, req_addr_in, req_data_in,
        input  req_ready_out, wren_out, wraddr_out, wrdata_out
    );
endinterface

// File: rtl/kanagawa_logic_ram_writer.sv
// Purpose: owns the logic-RAM write port; clears it to INIT_VALUE, then drains queued writes in order (KANAGAWA_LOGIC_RAM_WRITER_REINIT_EN adds init_start_in re-clear).
// Latency: request accepted in cycle N into an empty FIFO in RUN shows on wren_out in cycle N+1.
// Backpressure: req_ready_out drops only while the FIFO is full; it never looks at req_valid_in.
module kanagawa_logic_ram_writer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 2**ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic init_start_in,
    output logic init_done_out,
    output logic busy_out,
    kanagawa_logic_ram_writer_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      head, tail;
    logic [CNT_W-1:0]      count;

    logic                  push, store, pop, bypass, wr_fire, init_last, reinit;
    logic [ADDR_WIDTH-1:0] wr_addr_nxt;
    logic [DATA_WIDTH-1:0] wr_data_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef KANAGAWA_LOGIC_RAM_WRITER_REINIT_EN
    assign reinit = (state == ST_RUN) && init_start_in;
`else
    logic unused_init_start;
    assign unused_init_start = init_start_in;
    assign reinit = 1'b0;
`endif

    assign bus.req_ready_out = !rst && (count < CNT_W'(FIFO_DEPTH));
    assign busy_out          = (state == ST_INIT) || (count != '0);
    assign push              = bus.req_valid_in && bus.req_ready_out;
    assign init_last         = (init_cnt == LAST_ADDR);
    assign store             = push && !bypass;

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        bypass      = 1'b0;
        wr_fire     = 1'b0;
        wr_addr_nxt = fifo_addr[head];
        wr_data_nxt = fifo_data[head];
        case (state)
            ST_INIT: begin
                if (init_last) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    wr_fire = 1'b1;
                end else if (push && !reinit) begin
                    // Empty FIFO: the arriving request goes straight to the port.
                    // On a re-init edge it is queued instead so it lands after the clear.
                    bypass      = 1'b1;
                    wr_fire     = 1'b1;
                    wr_addr_nxt = bus.req_addr_in;
                    wr_data_nxt = bus.req_data_in;
                end
                if (reinit) state_nxt = ST_INIT;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_INIT;
            init_cnt       <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            init_done_out  <= 1'b0;
            bus.wren_out   <= 1'b0;
            bus.wraddr_out <= '0;
            bus.wrdata_out <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                bus.wren_out   <= 1'b1;
                bus.wraddr_out <= init_cnt;
                bus.wrdata_out <= INIT_VALUE;
                if (init_last) begin
                    init_cnt      <= '0;
                    init_done_out <= 1'b1;
                end else begin
                    init_cnt <= init_cnt + ADDR_WIDTH'(1);
                end
            end else begin
                bus.wren_out <= wr_fire;
                if (wr_fire) begin
                    bus.wraddr_out <= wr_addr_nxt;
                    bus.wrdata_out <= wr_data_nxt;
                end
                if (reinit) begin
                    init_cnt      <= '0;
                    init_done_out <= 1'b0;
                end
            end
            if (store) tail <= ptr_inc(tail);
            if (pop)   head <= ptr_inc(head);
            count <= count + CNT_W'(store) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: ready is low during rst, so nothing is stored then.
    always_ff @(posedge clk) begin
        if (store) begin
            fifo_addr[tail] <= bus.req_addr_in;
            fifo_data[tail] <= bus.req_data_in;
        end
    end
endmodule

// File: tb/tb_kanagawa_logic_ram_writer.sv
// Randomised self-checking bench for kanagawa_logic_ram_writer against a queue-based behavioural model.
module tb_kanagawa_logic_ram_writer;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int DEPTH = 8;
    localparam int FD = 2;
    localparam logic [DW-1:0] INITV = 16'h00A5;
`ifdef KANAGAWA_LOGIC_RAM_WRITER_REINIT_EN
    localparam int REINIT = 1;
`else
    localparam int REINIT = 0;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    logic clk = 1'b0;
    logic rst, init_start, init_done, busy;

    kanagawa_logic_ram_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    kanagawa_logic_ram_writer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .INIT_VALUE(INITV), .FIFO_DEPTH(FD)
    ) u_dut (
        .clk(clk), .rst(rst), .init_start_in(init_start),
        .init_done_out(init_done), .busy_out(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit rdy_seen;

    // Model: q holds accepted-but-unwritten requests in acceptance order.
    req_t q[$];
    req_t sent[$];
    req_t wlog[$];
    bit m_init, m_done, e_wren;
    int m_cnt;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic void model_edge();
        bit acc, rein;
        int had;
        req_t r, h;
        if (rst) begin
            m_init = 1; m_cnt = 0; m_done = 0;
            q.delete();
            e_wren = 0; e_addr = '0; e_data = '0;
        end else begin
            acc = bus.req_valid_in && (q.size() < FD);
            r.a = bus.req_addr_in;
            r.d = bus.req_data_in;
            if (m_init) begin
                e_wren = 1; e_addr = AW'(m_cnt); e_data = INITV;
                if (m_cnt == DEPTH - 1) begin
                    m_init = 0; m_done = 1;
                end
                m_cnt++;
                if (acc) q.push_back(r);
            end else begin
                rein = (REINIT != 0) && init_start;
                had = q.size();
                if (acc) q.push_back(r);
                if (had > 0 || (acc && !rein)) begin
                    h = q.pop_front();
                    e_wren = 1; e_addr = h.a; e_data = h.d;
                end else begin
                    e_wren = 0;
                end
                if (rein) begin
                    m_init = 1; m_cnt = 0; m_done = 0;
                end
            end
        end
    endfunction

    // Inputs are set at the negedge; one call advances one clock and checks everything.
    task automatic cycle();
        req_t w;
        #1;
        rdy_seen = bus.req_ready_out;
        check("ready", 32'(bus.req_ready_out), 32'(!rst && (q.size() < FD)));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check("wren", 32'(bus.wren_out), 32'(e_wren));
        check("wraddr", 32'(bus.wraddr_out), 32'(e_addr));
        check("wrdata", 32'(bus.wrdata_out), 32'(e_data));
        check("init_done", 32'(init_done), 32'(m_done));
        check("busy", 32'(busy), 32'(m_init || q.size() != 0));
        if (bus.wren_out && bus.wrdata_out != INITV) begin
            w.a = bus.wraddr_out;
            w.d = bus.wrdata_out;
            wlog.push_back(w);
        end
    endtask

    task automatic set_req(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid_in = v;
        bus.req_addr_in  = a;
        bus.req_data_in  = d;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        req_t r;
        ok = 0;
        set_req(1, a, d);
        for (int i = 0; i < 40 && !ok; i++) begin
            cycle();
            ok = rdy_seen;
        end
        set_req(0, '0, '0);
        check("send_accepted", 32'(ok), 32'd1);
        r.a = a;
        r.d = d;
        sent.push_back(r);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, 32'(wlog.size()), 32'(sent.size()));
        for (int i = 0; i < sent.size() && i < wlog.size(); i++) begin
            check({tag, "_addr"}, 32'(wlog[i].a), 32'(sent[i].a));
            check({tag, "_data"}, 32'(wlog[i].d), 32'(sent[i].d));
        end
    endtask

    initial begin
        int t0, lat;
        bit found;

        rst = 1; init_start = 0;
        set_req(0, '0, '0);
        repeat (3) cycle();

        // Power-up clear: eight init writes, then idle.
        rst = 0;
        repeat (DEPTH) cycle();
        check("s1_init_done", 32'(init_done), 32'd1);
        cycle();
        check("s1_idle_wren", 32'(bus.wren_out), 32'd0);

        // Single request into an empty FIFO in RUN.
        wlog.delete(); sent.delete();
        send(8'd3, 16'h1234);
        check("s2_wren", 32'(bus.wren_out), 32'd1);
        check("s2_addr", 32'(bus.wraddr_out), 32'd3);
        check("s2_data", 32'(bus.wrdata_out), 32'h1234);
        cycle();
        check("s2_busy", 32'(busy), 32'd0);
        compare_log("s2");

        // Three requests during INIT with a two-entry FIFO.
        rst = 1; cycle(); rst = 0;
        wlog.delete(); sent.delete();
        for (int i = 0; i < 3; i++)
            send(AW'($urandom_range(0, 255)), DW'($urandom) | 16'h8000);
        repeat (6) cycle();
        compare_log("s3");

        // Sixteen back-to-back requests in RUN.
        wlog.delete(); sent.delete();
        t0 = cyc;
        for (int i = 0; i < 16; i++)
            send(AW'($urandom_range(0, 255)), DW'($urandom) | 16'h8000);
        check("s4_cycles", 32'(cyc - t0), 32'd16);
        repeat (3) cycle();
        compare_log("s4");

        // Reset at init counter 5 with two queued requests.
        rst = 1; cycle(); rst = 0;
        wlog.delete(); sent.delete();
        send(8'h11, 16'hDEAD);
        send(8'h22, 16'hBEEF);
        repeat (3) cycle();
        rst = 1; cycle(); rst = 0;
        wlog.delete();
        repeat (DEPTH + 4) cycle();
        check("s5_no_stale", 32'(wlog.size()), 32'd0);

        // init_start pulse in RUN together with one request.
        wlog.delete();
        set_req(1, 8'h42, 16'h9ABC);
        init_start = 1;
        lat = 0; found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            set_req(0, '0, '0);
            init_start = (i == 3);
            lat++;
            found = (wlog.size() > 0);
        end
        init_start = 0;
        check("s6_found", 32'(found), 32'd1);
        check("s6_latency", 32'(lat), (REINIT != 0) ? 32'(DEPTH + 2) : 32'd1);
        if (wlog.size() > 0) begin
            check("s6_addr", 32'(wlog[0].a), 32'h42);
            check("s6_data", 32'(wlog[0].d), 32'h9ABC);
        end
        repeat (2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kanagawa_logic_ram_writer.md
Name: kanagawa_logic_ram_writer

Overview:
- Write-side sequencer that owns the single write port of a discrete-register logic RAM.
- Accepts write requests through a valid/ready handshake and buffers them in a small FIFO.
- Clears every RAM location to INIT_VALUE after reset, because the RAM itself has no reset. Queued requests are then drained in order, one RAM write per cycle.
- Sits between compiler-generated pipeline stages and the RAM write port (wren/wraddr/wrdata).

Parameters:
- DATA_WIDTH, 32, width of each RAM word.
- ADDR_WIDTH, 16, width of the RAM address.
- DEPTH, 2**ADDR_WIDTH, number of RAM words to initialise; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every location during initialisation.
- FIFO_DEPTH, 2, request buffer entries; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_in  in  1  write request valid
- req_ready_out  out  1  request accepted when valid & ready
- req_addr_in  in  ADDR_WIDTH  request address
- req_data_in  in  DATA_WIDTH  request data
- init_start_in  in  1  re-initialise pulse (see Optional Feature)
- wren_out  out  1  RAM write enable
- wraddr_out  out  ADDR_WIDTH  RAM write address
- wrdata_out  out  DATA_WIDTH  RAM write data
- init_done_out  out  1  high once initialisation has completed
- busy_out  out  1  high when in INIT or the FIFO is non-empty

Behaviour:
- One clock domain. Reset is synchronous and active-high, on ports clk and rst.
- State machine has two states, INIT and RUN. Reset enters INIT with the init counter at 0.
- Output reset values:
  - wren_out = 0, wraddr_out = 0, wrdata_out = 0.
  - init_done_out = 0, busy_out = 1.
  - req_ready_out = 0 while rst is high.
- All of wren_out, wraddr_out, wrdata_out and init_done_out are registered.
- req_ready_out = !rst & (fifo_count < FIFO_DEPTH). It is combinational and does not depend on req_valid_in.
- Requests are accepted in both INIT and RUN.
- A push and a pop in the same cycle both take effect, leaving the count unchanged.
- There is no same-cycle pass-through when the FIFO is full: ready is low, so no push occurs.
- INIT state:
  - Each cycle, the next cycle shows wren_out = 1, wraddr_out = counter, wrdata_out = INIT_VALUE.
  - The counter increments by 1 per cycle.
  - After the write to DEPTH-1 is issued, the block moves to RUN and init_done_out rises on that same edge.
  - Initialisation takes exactly DEPTH cycles. The FIFO is not popped during INIT.
- RUN state:
  - If the FIFO is non-empty, pop the head. The next cycle shows wren_out = 1 with the head's address and data.
  - Otherwise wren_out = 0. wraddr_out and wrdata_out hold their last values.
- Latency and ordering:
  - A request accepted in cycle N into an empty FIFO in RUN appears on wren_out in cycle N+1. It is readable from the RAM in cycle N+2.
  - Writes are emitted strictly in acceptance order.
  - Back-to-back requests sustain one write per cycle with req_ready_out continuously high.
- Addresses >= DEPTH are passed through unchanged. Keeping addresses in range is the requester's responsibility.
- Reset during INIT or RUN:
  - Discards FIFO contents and clears init_done_out.
  - Restarts initialisation from address 0.
- busy_out = (state == INIT) | (fifo_count != 0).

Optional Feature:
- Macro: KANAGAWA_LOGIC_RAM_WRITER_REINIT_EN.
- Defined:
  - init_start_in high in RUN moves the block to INIT on the next edge, with the counter at 0 and init_done_out cleared.
  - FIFO contents are retained and drained after the new initialisation completes.
  - init_start_in is ignored while already in INIT.
  - A pop already registered in the cycle init_start_in is sampled still appears on wren_out.
- Undefined: init_start_in is ignored. The block enters INIT only via rst.

Test Plan:
- DEPTH=8, INIT_VALUE=0xA5, release rst at cycle 0 -> wren_out high cycles 1..8, wraddr_out 0..7, wrdata_out 0xA5; init_done_out high from cycle 8; wren_out 0 at cycle 9.
- In RUN, push addr 3/data 0x1234 at cycle N with FIFO empty -> wren_out=1, wraddr_out=3, wrdata_out=0x1234 at cycle N+1; busy_out=0 at N+2.
- During INIT (DEPTH=8), push 3 requests with FIFO_DEPTH=2 -> first two accepted, req_ready_out=0 until INIT ends; all three written in order immediately after address 7.
- In RUN, valid held high for 16 cycles with random addr/data -> 16 consecutive wren_out pulses, data and order matching a scoreboard, ready never deasserted.
- Assert rst mid-INIT at counter=5 with 2 queued requests -> FIFO emptied, next writes restart at address 0, queued requests never written.
- With KANAGAWA_LOGIC_RAM_WRITER_REINIT_EN, pulse init_start_in in RUN with 1 queued request -> full DEPTH clear sequence, then the queued request written; without the macro, pulse has no effect.
